// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one burst memory port, one transaction in flight.
// Optional response watchdog is compiled in when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter #(
  parameter int unsigned num_req_p     = 4,
  parameter int unsigned width_words_p = 4,
  parameter int unsigned timeout_p     = 64
) (
  input  logic                                    clk_i,
  input  logic                                    nreset_i,
  input  logic [num_req_p-1:0]                    req_valid_i,
  output logic [num_req_p-1:0]                    req_ready_o,
  input  logic [num_req_p-1:0]                    req_we_i,
  input  logic [num_req_p-1:0][31:0]              req_addr_i,
  input  logic [num_req_p-1:0][width_words_p*32-1:0] req_wdata_i,
  output logic [num_req_p-1:0]                    resp_valid_o,
  output logic [width_words_p*32-1:0]             resp_data_o,
  output logic                                    mem_valid_o,
  input  logic                                    mem_ready_i,
  output logic                                    mem_we_o,
  output logic [31:0]                             mem_addr_o,
  output logic [width_words_p*32-1:0]             mem_wdata_o,
  input  logic                                    mem_valid_i,
  input  logic [width_words_p*32-1:0]             mem_data_i,
  output logic                                    error_o
);

  localparam int unsigned idx_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  if (num_req_p < 2 || timeout_p == 0) begin : g_cfg_check
    $error("mem_arbiter: num_req_p must be >= 2 and timeout_p must be nonzero");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_e;

  state_e               state;
  logic [idx_w_lp-1:0]  rr_ptr;
  logic [idx_w_lp-1:0]  grant_idx;
  logic [idx_w_lp-1:0]  winner;
  logic [idx_w_lp-1:0]  cand;
  logic                 found;
  logic [num_req_p-1:0] grant_onehot;
  logic                 timeout_hit;

  // Search starts just after the last served requester, so it ends up lowest priority.
  always_comb begin
    winner = rr_ptr;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned k = 1; k <= num_req_p; k++) begin
      cand = idx_w_lp'((32'(rr_ptr) + k) % num_req_p);
      if (!found && req_valid_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (state == ST_IDLE && found) begin
      req_ready_o[winner] = 1'b1;
    end
  end

  always_comb begin
    grant_onehot            = '0;
    grant_onehot[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state        <= ST_IDLE;
      rr_ptr       <= idx_w_lp'(num_req_p - 1);
      grant_idx    <= '0;
      mem_valid_o  <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      resp_valid_o <= '0;
      resp_data_o  <= '0;
    end else begin
      resp_valid_o <= '0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            grant_idx   <= winner;
            mem_we_o    <= req_we_i[winner];
            mem_addr_o  <= req_addr_i[winner];
            mem_wdata_o <= req_wdata_i[winner];
            mem_valid_o <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (timeout_hit) begin
            mem_valid_o  <= 1'b0;
            resp_valid_o <= grant_onehot;
            rr_ptr       <= grant_idx;
            state        <= ST_IDLE;
          end else if (mem_ready_i) begin
            mem_valid_o <= 1'b0;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A real response arriving on the watchdog cycle wins over the timeout.
          if (mem_valid_i) begin
            resp_valid_o <= grant_onehot;
            resp_data_o  <= mem_data_i;
            rr_ptr       <= grant_idx;
            state        <= ST_IDLE;
          end else if (timeout_hit) begin
            resp_valid_o <= grant_onehot;
            rr_ptr       <= grant_idx;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned tmo_w_lp = $clog2(timeout_p + 1);

  logic [tmo_w_lp-1:0] tmo_cnt;
  logic                err_q;

  assign timeout_hit = (state != ST_IDLE) && (tmo_cnt == tmo_w_lp'(timeout_p - 1));
  assign error_o     = err_q;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == ST_IDLE) begin
        tmo_cnt <= '0;
      end else if (!timeout_hit) begin
        tmo_cnt <= tmo_cnt + tmo_w_lp'(1);
      end
      if (timeout_hit && !(state == ST_WAIT && mem_valid_i)) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign error_o     = 1'b0;
`endif

`ifndef SYNTHESIS
  mem_resp_only_in_wait_a : assert property (
    @(posedge clk_i) disable iff (!nreset_i) mem_valid_i |-> (state == ST_WAIT)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized requesters and memory,
// checked against a transaction-level round-robin reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int unsigned NR  = 4;
  localparam int unsigned WW  = 4;
  localparam int unsigned DW  = WW * 32;
  localparam int unsigned TMO = 16;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   nreset_i = 1'b0;
  logic [NR-1:0]          req_valid_i = '0;
  logic [NR-1:0]          req_ready_o;
  logic [NR-1:0]          req_we_i = '0;
  logic [NR-1:0][31:0]    req_addr_i = '0;
  logic [NR-1:0][DW-1:0]  req_wdata_i = '0;
  logic [NR-1:0]          resp_valid_o;
  logic [DW-1:0]          resp_data_o;
  logic                   mem_valid_o;
  logic                   mem_ready_i = 1'b1;
  logic                   mem_we_o;
  logic [31:0]            mem_addr_o;
  logic [DW-1:0]          mem_wdata_o;
  logic                   mem_valid_i = 1'b0;
  logic [DW-1:0]          mem_data_i = '0;
  logic                   error_o;

  always #5 clk = ~clk;

  mem_arbiter #(
    .num_req_p    (NR),
    .width_words_p(WW),
    .timeout_p    (TMO)
  ) dut (
    .clk_i       (clk),
    .nreset_i    (nreset_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .resp_valid_o(resp_valid_o),
    .resp_data_o (resp_data_o),
    .mem_valid_o (mem_valid_o),
    .mem_ready_i (mem_ready_i),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_valid_i (mem_valid_i),
    .mem_data_i  (mem_data_i),
    .error_o     (error_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned   who;
    int unsigned   at;
    logic [DW-1:0] data;
  } ev_t;

  ev_t           grant_log[$];
  ev_t           resp_log[$];
  int unsigned   cyc = 0;
  int unsigned   last_srv = NR - 1;
  int unsigned   owner = 0;
  int unsigned   age = 0;
  int            pick_w;
  bit            busy = 0, issuing = 0, waiting = 0, resp_due = 0, resp_tmo = 0, exp_err = 0;
  logic          exp_we;
  logic [31:0]   exp_addr;
  logic [DW-1:0] exp_wdata, exp_rdata;

  function automatic int rr_pick(input logic [NR-1:0] v, input int unsigned last);
    for (int unsigned k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) return int'((last + k) % NR);
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!nreset_i) begin
      check_eq("rst_req_ready", DW'(req_ready_o), '0);
      check_eq("rst_resp_valid", DW'(resp_valid_o), '0);
      check_eq("rst_mem_valid", DW'(mem_valid_o), '0);
      check_eq("rst_error", DW'(error_o), '0);
      last_srv = NR - 1;
      busy = 0; issuing = 0; waiting = 0; resp_due = 0; resp_tmo = 0; exp_err = 0;
    end else begin
      check_eq("error", DW'(error_o), DW'(exp_err));
      if (resp_due) begin
        check_eq("resp_valid", DW'(resp_valid_o), DW'(1) << owner);
        if (!exp_we && !resp_tmo) check_eq("resp_data", resp_data_o, exp_rdata);
        resp_log.push_back('{who: owner, at: cyc, data: resp_data_o});
        last_srv = owner;
        busy = 0;
        resp_due = 0;
      end else begin
        check_eq("resp_quiet", DW'(resp_valid_o), '0);
      end

      check_eq("mem_valid", DW'(mem_valid_o), DW'(issuing));
      if (waiting) begin
        age++;
        if (mem_valid_i) begin
          exp_rdata = mem_data_i;
          waiting = 0; resp_due = 1; resp_tmo = 0;
        end else if (TMO_ON && age == TMO) begin
          waiting = 0; resp_due = 1; resp_tmo = 1; exp_err = 1;
        end
      end else if (issuing) begin
        age++;
        check_eq("mem_we", DW'(mem_we_o), DW'(exp_we));
        check_eq("mem_addr", DW'(mem_addr_o), DW'(exp_addr));
        check_eq("mem_wdata", mem_wdata_o, exp_wdata);
        if (TMO_ON && age == TMO) begin
          issuing = 0; resp_due = 1; resp_tmo = 1; exp_err = 1;
        end else if (mem_ready_i) begin
          issuing = 0; waiting = 1;
        end
      end

      pick_w = busy ? -1 : rr_pick(req_valid_i, last_srv);
      if (pick_w < 0) begin
        check_eq("req_ready", DW'(req_ready_o), '0);
      end else begin
        check_eq("req_ready", DW'(req_ready_o), DW'(1) << pick_w);
        owner     = pick_w;
        busy      = 1;
        issuing   = 1;
        age       = 0;
        exp_we    = req_we_i[owner];
        exp_addr  = req_addr_i[owner];
        exp_wdata = req_wdata_i[owner];
        grant_log.push_back('{who: owner, at: cyc, data: '0});
      end
    end
  end

  // ---------------- memory responder ----------------
  logic [DW-1:0] store [logic [31:0]];
  int unsigned   mem_delay = 0;
  int unsigned   rsp_cnt = 0;
  int unsigned   stall_run = 0;
  bit            rsp_pend = 0, rdy_low = 0, rdy_rand = 0, mem_silent = 0;
  logic [DW-1:0] rsp_data = '0;

  function automatic logic [DW-1:0] mem_read(input logic [31:0] a);
    if (store.exists(a)) return store[a];
    return {~a, a ^ 32'h5a5a_5a5a, a + 32'd1, a};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (mem_valid_i) rsp_pend = 0;
      if (nreset_i && mem_valid_o && mem_ready_i) begin
        if (mem_we_o) store[mem_addr_o] = mem_wdata_o;
        rsp_data = mem_we_o ? DW'({$urandom, $urandom, $urandom, $urandom}) : mem_read(mem_addr_o);
        rsp_cnt  = (mem_delay != 0) ? mem_delay : $urandom_range(4, 1);
        rsp_pend = !mem_silent;
      end
      @(posedge clk);
      #1;
      if (rsp_pend && rsp_cnt > 0) rsp_cnt--;
      mem_valid_i = rsp_pend && (rsp_cnt == 0);
      mem_data_i  = mem_valid_i ? rsp_data : DW'({$urandom, $urandom, $urandom, $urandom});
      if (rdy_low) begin
        mem_ready_i = 1'b0;
      end else if (rdy_rand && stall_run < 3 && $urandom_range(1, 0) == 1) begin
        mem_ready_i = 1'b0;
        stall_run++;
      end else begin
        mem_ready_i = 1'b1;
        stall_run = 0;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned i, input logic we, input logic [31:0] a,
                         input logic [DW-1:0] d);
    req_valid_i[i] = 1'b1;
    req_we_i[i]    = we;
    req_addr_i[i]  = a;
    req_wdata_i[i] = d;
  endtask

  task automatic wait_grants(input int unsigned n);
    for (int k = 0; k < 200 && grant_log.size() < n; k++) tick();
    check_eq("grant_wait", DW'(grant_log.size() >= n), DW'(1));
  endtask

  task automatic wait_resps(input int unsigned n);
    for (int k = 0; k < 200 && resp_log.size() < n; k++) tick();
    check_eq("resp_wait", DW'(resp_log.size() >= n), DW'(1));
  endtask

  task automatic xfer(input int unsigned i, input logic we, input logic [31:0] a,
                      input logic [DW-1:0] d);
    int unsigned g, n;
    g = grant_log.size();
    n = resp_log.size();
    set_req(i, we, a, d);
    wait_grants(g + 1);
    req_valid_i[i] = 1'b0;
    wait_resps(n + 1);
  endtask

  task automatic drain();
    req_valid_i = '0;
    for (int k = 0; k < 100 && busy; k++) tick();
    check_eq("drain", DW'(busy), '0);
    tick();
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int unsigned g, n;
    ev_t e, r;
    logic [DW-1:0] pat;

    store[32'h40] = {32'h4, 32'h3, 32'h2, 32'h1};
    repeat (3) tick();
    nreset_i = 1'b1;
    tick();

    // single read, memory delay 3: response 5 cycles after accept
    mem_delay = 3;
    xfer(2, 1'b0, 32'h40, '0);
    e = grant_log[$];
    r = resp_log[$];
    check_eq("rd_grant_who", DW'(e.who), DW'(2));
    check_eq("rd_resp_who", DW'(r.who), DW'(2));
    check_eq("rd_data", r.data, {32'h4, 32'h3, 32'h2, 32'h1});
    check_eq("rd_latency", DW'(r.at - e.at), DW'(5));
    mem_delay = 0;
    drain();

    // write then read back the same address
    xfer(1, 1'b1, 32'h80, {96'h0, 32'hDEADBEEF});
    r = resp_log[$];
    check_eq("wr_ack_who", DW'(r.who), DW'(1));
    xfer(1, 1'b0, 32'h80, '0);
    r = resp_log[$];
    check_eq("rd_after_wr", r.data, {96'h0, 32'hDEADBEEF});
    drain();

    // memory holds mem_ready_i low for 5 cycles while others wait
    rdy_low = 1;
    pat = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
    g = grant_log.size();
    set_req(1, 1'b1, 32'h100, pat);
    wait_grants(g + 1);
    req_valid_i[1] = 1'b0;
    set_req(0, 1'b0, 32'h10, '0);
    set_req(2, 1'b0, 32'h20, '0);
    set_req(3, 1'b0, 32'h30, '0);
    for (int k = 0; k < 5; k++) begin
      check_eq("stall_valid", DW'(mem_valid_o), DW'(1));
      check_eq("stall_addr", DW'(mem_addr_o), DW'(32'h100));
      check_eq("stall_wdata", mem_wdata_o, pat);
      check_eq("stall_ready", DW'(req_ready_o), '0);
      tick();
    end
    rdy_low = 0;
    drain();

    // reset while waiting for the memory; the response lands during reset
    mem_delay = 6;
    g = grant_log.size();
    n = resp_log.size();
    set_req(3, 1'b0, 32'h200, '0);
    wait_grants(g + 1);
    req_valid_i = '0;
    tick();
    tick();
    nreset_i = 1'b0;
    repeat (8) tick();
    nreset_i = 1'b1;
    repeat (3) tick();
    check_eq("abort_no_resp", DW'(resp_log.size()), DW'(n));
    mem_delay = 0;

    // all requesters valid continuously after reset: strict rotation from 0
    g = grant_log.size();
    for (int unsigned i = 0; i < NR; i++) set_req(i, 1'b0, 32'(i * 16), '0);
    wait_grants(g + 5);
    for (int unsigned j = 0; j < 5; j++) begin
      if (g + j < grant_log.size()) begin
        e = grant_log[g + j];
        check_eq("rotation", DW'(e.who), DW'(j % NR));
      end
    end
    drain();

`ifdef MEM_ARB_TIMEOUT_EN
    // silent memory: watchdog answers 16 cycles after ISSUE entry
    mem_silent = 1;
    xfer(0, 1'b0, 32'h300, '0);
    e = grant_log[$];
    r = resp_log[$];
    check_eq("tmo_who", DW'(r.who), DW'(0));
    check_eq("tmo_latency", DW'(r.at - e.at), DW'(TMO + 1));
    check_eq("tmo_error", DW'(error_o), DW'(1));
    mem_silent = 0;
    drain();
    xfer(2, 1'b0, 32'h40, '0);
    r = resp_log[$];
    check_eq("tmo_after_data", r.data, {32'h4, 32'h3, 32'h2, 32'h1});
    check_eq("tmo_sticky", DW'(error_o), DW'(1));
    drain();
`endif

    // randomized traffic with memory stalls and variable delay
    rdy_rand = 1;
    for (int k = 0; k < 3000; k++) begin
      req_valid_i = NR'($urandom);
      for (int unsigned i = 0; i < NR; i++) begin
        req_we_i[i]    = $urandom_range(1, 0) == 1;
        req_addr_i[i]  = 32'($urandom_range(15, 0)) << 4;
        req_wdata_i[i] = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
    end
    rdy_rand = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
